// File: rtl/crossy_pkg.sv
// rtl/crossy_pkg.sv - shared geometry, colours and pixel classes for the lane renderer
package crossy_pkg;

  localparam logic [9:0] H_ACTIVE  = 10'd640;
  localparam logic [9:0] V_ACTIVE  = 10'd480;
  localparam int         LANE_H    = 32;
  localparam int         NUM_LANES = 15;
  localparam logic [9:0] CAR_W     = 10'd48;
  localparam logic [9:0] CAR_GAP   = 10'd320;
  localparam logic [9:0] PLAYER_X  = 10'd304;
  localparam logic [9:0] PLAYER_Y  = 10'd416;
  localparam logic [9:0] PLAYER_S  = 10'd32;
  localparam int         CAR_SPACING = 40;

  typedef struct packed {
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
  } rgb_t;

  localparam rgb_t COL_BLANK  = 6'b00_00_00;
  localparam rgb_t COL_PLAYER = 6'b11_11_00;
  localparam rgb_t COL_CAR    = 6'b11_00_00;
  localparam rgb_t COL_ROAD   = 6'b01_01_01;
  localparam rgb_t COL_GRASS  = 6'b00_10_00;

  typedef enum logic [2:0] {
    CLS_BLANK,
    CLS_PLAYER,
    CLS_CAR,
    CLS_ROAD,
    CLS_GRASS
  } pix_cls_t;

endpackage

// File: rtl/lane_car_ctr.sv
// rtl/lane_car_ctr.sv - per-lane car position, advanced once per frame tick with wrap
module lane_car_ctr
  import crossy_pkg::*;
#(
  parameter int LANE_IDX = 0,
  parameter int RESET_X  = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_tick,
  input  logic [1:0] i_level,
  output logic [9:0] o_car_x
);

  localparam logic       IS_ROAD  = (LANE_IDX % 3) != 0;
  localparam logic       MOVE_UP  = (LANE_IDX % 2) == 1;
  localparam logic [3:0] BASE_SPD = 4'(1 + (LANE_IDX % 4));

  logic [9:0]  r_car_x;
  logic [3:0]  w_spd;
  logic [10:0] w_sum;
  logic [10:0] w_sum_wrap;
  logic [9:0]  w_next;

  always_comb begin
    w_spd      = BASE_SPD + {2'b00, i_level};
    w_sum      = {1'b0, r_car_x} + {7'd0, w_spd};
    w_sum_wrap = w_sum - {1'b0, H_ACTIVE};
    w_next     = r_car_x;
    if (MOVE_UP) begin
      w_next = (w_sum >= {1'b0, H_ACTIVE}) ? w_sum_wrap[9:0] : w_sum[9:0];
    end else begin
      // Left-moving: borrow a full line width before subtracting so x stays in 0..639.
      w_next = (r_car_x < {6'd0, w_spd}) ? (r_car_x + H_ACTIVE - {6'd0, w_spd})
                                         : (r_car_x - {6'd0, w_spd});
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_car_x <= 10'(RESET_X);
    end else if (i_tick && IS_ROAD) begin
      r_car_x <= w_next;
    end
  end

  assign o_car_x = r_car_x;

endmodule

// File: rtl/lane_render.sv
// rtl/lane_render.sv - scrolling lane/car/player renderer with per-frame collision pulse
module lane_render
  import crossy_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic       display_on,
  input  logic [9:0] y_pos,
  input  logic [7:0] score,
  output logic [1:0] r,
  output logic [1:0] g,
  output logic [1:0] b,
  output logic       collision
);

  logic [9:0] r_y_lat;
  logic [1:0] r_level;
  logic       r_hit_acc;
  logic       r_collision;
  rgb_t       r_rgb;

  logic       w_tick;
  logic [9:0] w_car_x [NUM_LANES];
  logic [9:0] w_wy;
  logic [4:0] w_lane;
  logic [4:0] w_row;
  logic       w_in_v;
  logic       w_road;
  logic [9:0] w_car_sel;
  logic [9:0] w_d;
  logic [9:0] w_d2;
  logic       w_car;
  logic       w_player;
  logic [7:0] w_lvl_full;
  logic [1:0] w_level_next;
  pix_cls_t   w_cls;
  rgb_t       w_rgb;

  assign w_tick = (hpos == 10'd0) && (vpos == V_ACTIVE);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lane_car_ctr #(
      .LANE_IDX (i),
      .RESET_X  (i * CAR_SPACING)
    ) u_ctr (
      .clk     (clk),
      .reset   (reset),
      .i_tick  (w_tick),
      .i_level (r_level),
      .o_car_x (w_car_x[i])
    );
  end

  always_comb begin
    w_in_v    = vpos < V_ACTIVE;
    w_wy      = (vpos >= r_y_lat) ? (vpos - r_y_lat) : (vpos + V_ACTIVE - r_y_lat);
    w_lane    = w_wy[9:5];
    w_row     = w_wy[4:0];
    w_road    = w_in_v && (w_lane < 5'd15) && ((w_lane % 5'd3) != 5'd0);
    w_car_sel = (w_lane < 5'd15) ? w_car_x[w_lane[3:0]] : 10'd0;
    // Distance from the lane's first car, folded so both cars of the lane share one compare.
    w_d       = (hpos >= w_car_sel) ? (hpos - w_car_sel) : (hpos + H_ACTIVE - w_car_sel);
    w_d2      = (w_d >= CAR_GAP) ? (w_d - CAR_GAP) : w_d;
    w_car     = w_road && (w_row >= 5'd4) && (w_row <= 5'd27) && (w_d2 < CAR_W);
    w_player  = (hpos >= PLAYER_X) && (hpos < PLAYER_X + PLAYER_S) &&
                (vpos >= PLAYER_Y) && (vpos < PLAYER_Y + PLAYER_S);
  end

  always_comb begin
    w_cls = CLS_BLANK;
    if (!display_on)   w_cls = CLS_BLANK;
    else if (w_player) w_cls = CLS_PLAYER;
    else if (w_car)    w_cls = CLS_CAR;
    else if (w_road)   w_cls = CLS_ROAD;
    else               w_cls = CLS_GRASS;

    w_rgb = COL_BLANK;
    case (w_cls)
      CLS_PLAYER: w_rgb = COL_PLAYER;
      CLS_CAR:    w_rgb = COL_CAR;
      CLS_ROAD:   w_rgb = COL_ROAD;
      CLS_GRASS:  w_rgb = COL_GRASS;
      default:    w_rgb = COL_BLANK;
    endcase
  end

  always_comb begin
    w_lvl_full   = score >> 3;
    w_level_next = (w_lvl_full >= 8'd3) ? 2'd3 : w_lvl_full[1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_y_lat     <= '0;
      r_level     <= '0;
      r_hit_acc   <= 1'b0;
      r_collision <= 1'b0;
      r_rgb       <= COL_BLANK;
    end else begin
      r_rgb <= w_rgb;
      if (w_tick) begin
        r_y_lat     <= (y_pos >= V_ACTIVE) ? 10'd0 : y_pos;
        r_level     <= w_level_next;
        r_collision <= r_hit_acc;
        r_hit_acc   <= 1'b0;
      end else begin
        r_collision <= 1'b0;
        r_hit_acc   <= r_hit_acc | (display_on & w_player & w_car);
      end
    end
  end

  assign r         = r_rgb.r;
  assign g         = r_rgb.g;
  assign b         = r_rgb.b;
  assign collision = r_collision;

endmodule

// File: tb/tb_lane_render.sv
// tb/tb_lane_render.sv - directed self-checking bench for lane_render
module tb_lane_render;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       display_on;
  logic [9:0] y_pos;
  logic [7:0] score;
  logic [1:0] r, g, b;
  logic       collision;

  int checks = 0;
  int errors = 0;

  localparam logic [5:0] C_BLANK  = 6'b00_00_00;
  localparam logic [5:0] C_PLAYER = 6'b11_11_00;
  localparam logic [5:0] C_CAR    = 6'b11_00_00;
  localparam logic [5:0] C_ROAD   = 6'b01_01_01;
  localparam logic [5:0] C_GRASS  = 6'b00_10_00;

  lane_render dut (
    .clk        (clk),
    .reset      (reset),
    .hpos       (hpos),
    .vpos       (vpos),
    .display_on (display_on),
    .y_pos      (y_pos),
    .score      (score),
    .r          (r),
    .g          (g),
    .b          (b),
    .collision  (collision)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input int h, input int v, input logic d);
    hpos       = 10'(h);
    vpos       = 10'(v);
    display_on = d;
    step();
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) pix(0, 480, 1'b0);
  endtask

  initial begin
    reset = 1'b1; hpos = 10'd0; vpos = 10'd40; display_on = 1'b1;
    y_pos = 10'd0; score = 8'd0;
    step(); step();
    check("reset_rgb", {26'd0, r, g, b}, {26'd0, C_BLANK});
    check("reset_collision", {31'd0, collision}, 32'd0);
    for (int i = 0; i < 15; i++) check($sformatf("reset_car_x%0d", i), {22'd0, dut.w_car_x[i]}, 32'(i * 40));
    reset = 1'b0;

    pix(0, 40, 1'b1);    check("road_lane1",       {26'd0, r, g, b}, {26'd0, C_ROAD});
    pix(50, 40, 1'b1);   check("car_lane1",        {26'd0, r, g, b}, {26'd0, C_CAR});
    pix(360, 40, 1'b1);  check("car2_lane1",       {26'd0, r, g, b}, {26'd0, C_CAR});
    pix(87, 40, 1'b1);   check("car_right_edge",   {26'd0, r, g, b}, {26'd0, C_CAR});
    pix(88, 40, 1'b1);   check("car_past_edge",    {26'd0, r, g, b}, {26'd0, C_ROAD});
    pix(50, 35, 1'b1);   check("car_row3",         {26'd0, r, g, b}, {26'd0, C_ROAD});
    pix(50, 36, 1'b1);   check("car_row4",         {26'd0, r, g, b}, {26'd0, C_CAR});
    pix(50, 59, 1'b1);   check("car_row27",        {26'd0, r, g, b}, {26'd0, C_CAR});
    pix(50, 60, 1'b1);   check("car_row28",        {26'd0, r, g, b}, {26'd0, C_ROAD});
    pix(304, 416, 1'b1); check("player_corner",    {26'd0, r, g, b}, {26'd0, C_PLAYER});
    pix(50, 40, 1'b0);   check("blank_display_off",{26'd0, r, g, b}, {26'd0, C_BLANK});

    // Tick A: scroll by one lane, first car step at level 0.
    y_pos = 10'd32;
    tick(1);
    check("tickA_collision", {31'd0, collision}, 32'd0);
    check("tickA_car_x1", {22'd0, dut.w_car_x[1]}, 32'd42);
    check("tickA_car_x2", {22'd0, dut.w_car_x[2]}, 32'd77);
    check("tickA_car_x3_grass", {22'd0, dut.w_car_x[3]}, 32'd120);
    pix(0, 40, 1'b1);    check("scrolled_grass",   {26'd0, r, g, b}, {26'd0, C_GRASS});

    // Tick B: map player rows onto lane 7 (car_x 288 covers the player).
    y_pos = 10'd192;
    tick(1);
    check("tickB_car_x7", {22'd0, dut.w_car_x[7]}, 32'd288);
    pix(290, 430, 1'b1); check("lane7_car",        {26'd0, r, g, b}, {26'd0, C_CAR});
    pix(320, 430, 1'b0); check("overlap_disp_off", {26'd0, r, g, b}, {26'd0, C_BLANK});
    tick(1);
    check("tickC_no_collision", {31'd0, collision}, 32'd0);
    pix(310, 430, 1'b1); check("overlap_yellow",   {26'd0, r, g, b}, {26'd0, C_PLAYER});
    check("no_pulse_midframe", {31'd0, collision}, 32'd0);
    tick(1);
    check("tickD_collision", {31'd0, collision}, 32'd1);
    pix(304, 444, 1'b1);
    check("pulse_one_cycle", {31'd0, collision}, 32'd0);
    check("player_row28",    {26'd0, r, g, b}, {26'd0, C_PLAYER});
    tick(1);
    check("tickE_no_collision", {31'd0, collision}, 32'd0);
    check("tickE_car_x1", {22'd0, dut.w_car_x[1]}, 32'd50);
    check("tickE_car_x2", {22'd0, dut.w_car_x[2]}, 32'd65);

    // Wrap: lane 2 moves left by 3, lane 1 right by 2.
    tick(21);
    check("lane2_pre_wrap", {22'd0, dut.w_car_x[2]}, 32'd2);
    tick(1);
    check("lane2_wrap", {22'd0, dut.w_car_x[2]}, 32'd639);
    check("lane1_94",   {22'd0, dut.w_car_x[1]}, 32'd94);
    tick(272);
    check("lane1_pre_wrap", {22'd0, dut.w_car_x[1]}, 32'd638);
    tick(1);
    check("lane1_wrap", {22'd0, dut.w_car_x[1]}, 32'd0);

    // Level latches on a tick and applies from the following tick.
    score = 8'd24;
    tick(1);
    check("level_latch_tick", {22'd0, dut.w_car_x[1]}, 32'd2);
    tick(1);
    check("level3_speed", {22'd0, dut.w_car_x[1]}, 32'd7);
    score = 8'd0;
    tick(1);
    check("level3_held", {22'd0, dut.w_car_x[1]}, 32'd12);
    tick(1);
    check("level0_again", {22'd0, dut.w_car_x[1]}, 32'd14);

    // Out-of-range scroll offset latches as 0.
    y_pos = 10'd500;
    tick(1);
    pix(0, 0, 1'b1);     check("y_clamp_grass",   {26'd0, r, g, b}, {26'd0, C_GRASS});

    // Reset mid-frame.
    reset = 1'b1;
    pix(50, 40, 1'b1);
    check("midreset_rgb",    {26'd0, r, g, b}, {26'd0, C_BLANK});
    check("midreset_car_x1", {22'd0, dut.w_car_x[1]}, 32'd40);
    reset = 1'b0;
    pix(50, 40, 1'b1);   check("post_reset_car",  {26'd0, r, g, b}, {26'd0, C_CAR});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
